// File: rtl/uart_tx_flow_pkg.sv
// Shared UART definitions: transmitter FSM states, frame width, baud divisor helper.
package uart_tx_flow_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    // Clock cycles per serial bit.
    function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered write and first-word-fall-through read.
// Ports:
//   sys_clk, rstn       clock, synchronous active-low reset
//   push, push_data     write request/data (ignored while full)
//   pop, pop_data       read request (ignored while empty), head entry
//   full, empty, count  occupancy status
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         sys_clk,
    input  logic                         rstn,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_sync_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rptr];

    // Storage array; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_flow.sv
// UART 8N1 transmitter with TX FIFO and rts flow control.
// Ports:
//   sys_clk, rstn        clock, synchronous active-low reset
//   wr_valid, wr_data    byte offered by the core
//   wr_ready             FIFO has room
//   rts                  asynchronous peer-ready input
//   txd                  serial line, idle high
//   busy                 frame in progress
//   fifo_count           bytes queued and not yet started
module uart_tx_flow
    import uart_tx_flow_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 10000000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                              sys_clk,
    input  logic                              rstn,
    input  logic                              wr_valid,
    input  logic [7:0]                        wr_data,
    output logic                              wr_ready,
    input  logic                              rts,
    output logic                              txd,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int unsigned BAUD_DIV  = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned IW        = $clog2(UART_DATA_BITS);
    localparam logic [BW-1:0] BCNT_LAST = BW'(BAUD_DIV - 1);
    localparam logic [IW-1:0] BIDX_LAST = IW'(UART_DATA_BITS - 1);

    if (BAUD_DIV < 2) begin : g_bad_div
        $error("uart_tx_flow: CLK_FREQ/BAUD must be at least 2");
    end

    uart_tx_state_t              state;
    logic [BW-1:0]               bcnt;
    logic [IW-1:0]               bidx;
    logic [UART_DATA_BITS-1:0]   sh;
    logic                        rts_meta;
    logic                        rts_s;
    logic [UART_DATA_BITS-1:0]   head;
    logic                        full;
    logic                        empty;
    logic                        bit_end_c;
    logic                        pop_c;

    assign wr_ready  = !full;
    assign bit_end_c = (bcnt == BCNT_LAST);
    // A frame may start from IDLE or straight out of the last STOP cycle.
    assign pop_c     = !empty && rts_s &&
                       ((state == IDLE) || ((state == STOP) && bit_end_c));

    uart_sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .rstn      (rstn),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (pop_c),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    // Two-flop synchroniser for the asynchronous rts input.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            rts_meta <= 1'b0;
            rts_s    <= 1'b0;
        end else begin
            rts_meta <= rts;
            rts_s    <= rts_meta;
        end
    end

    // Frame sequencer; txd/busy are registered from the current state,
    // so the line lags the state by one cycle.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state <= IDLE;
            bcnt  <= '0;
            bidx  <= '0;
            sh    <= '0;
            txd   <= 1'b1;
            busy  <= 1'b0;
        end else begin
            case (state)
                START:   txd <= 1'b0;
                DATA:    txd <= sh[0];
                default: txd <= 1'b1;
            endcase
            busy <= (state != IDLE);

            case (state)
                IDLE: begin
                    if (pop_c) begin
                        sh    <= head;
                        bcnt  <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end_c) begin
                        bcnt  <= '0;
                        bidx  <= '0;
                        state <= DATA;
                    end else begin
                        bcnt <= bcnt + BW'(1);
                    end
                end
                DATA: begin
                    if (bit_end_c) begin
                        bcnt <= '0;
                        sh   <= {1'b0, sh[UART_DATA_BITS-1:1]};
                        if (bidx == BIDX_LAST) begin
                            state <= STOP;
                        end else begin
                            bidx <= bidx + IW'(1);
                        end
                    end else begin
                        bcnt <= bcnt + BW'(1);
                    end
                end
                STOP: begin
                    if (bit_end_c) begin
                        bcnt <= '0;
                        if (pop_c) begin
                            sh    <= head;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bcnt <= bcnt + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_flow.sv
// Bench for uart_tx_flow: per-cycle timeline model, line decoder, directed scenarios.
module tb_uart_tx_flow;

    localparam int DIV   = 100000000 / 10000000;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * DIV;

    logic       sys_clk = 1'b0;
    logic       rstn    = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data  = 8'h00;
    logic       rts      = 1'b1;
    logic       wr_ready;
    logic       txd;
    logic       busy;
    logic [3:0] fifo_count;

    int checks   = 0;
    int failures = 0;

    uart_tx_flow dut (
        .sys_clk    (sys_clk),
        .rstn       (rstn),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rts        (rts),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial forever #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Line level of a frame carrying b, at bit slot idx (0 = start, 9 = stop).
    function automatic logic line_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    // Model: a queue of pending bytes and the age of the frame on the line.
    logic [7:0] mq[$];
    logic       m_active = 1'b0;
    int         m_age    = 0;
    logic [7:0] m_cur    = 8'h00;
    logic       m_r1     = 1'b0;
    logic       m_r2     = 1'b0;
    int         m_before;
    logic       m_end;
    logic       e_txd    = 1'b1;
    logic       e_busy   = 1'b0;
    int         e_count  = 0;
    logic       e_ready  = 1'b1;

    // Line decoder results.
    logic [7:0] rx_q[$];
    logic       rx_active = 1'b0;
    int         rx_t      = 0;
    logic [7:0] rx_byte   = 8'h00;

    always begin
        @(posedge sys_clk);
        if (!rstn) begin
            mq.delete();
            m_active = 1'b0;
            m_age    = 0;
            m_r1     = 1'b0;
            m_r2     = 1'b0;
            e_txd    = 1'b1;
            e_busy   = 1'b0;
        end else begin
            m_before = mq.size();
            m_end    = 1'b0;
            if (m_active) begin
                e_busy = 1'b1;
                e_txd  = line_bit(m_cur, m_age / DIV);
                m_end  = (m_age == FRAME - 1);
                m_age++;
            end else begin
                e_busy = 1'b0;
                e_txd  = 1'b1;
            end
            if ((!m_active || m_end) && m_before > 0 && m_r2) begin
                m_cur    = mq.pop_front();
                m_active = 1'b1;
                m_age    = 0;
            end else if (m_end) begin
                m_active = 1'b0;
            end
            if (wr_valid && m_before < DEPTH) mq.push_back(wr_data);
            m_r2 = m_r1;
            m_r1 = rts;
        end
        e_count = mq.size();
        e_ready = (mq.size() != DEPTH);
        #1;
        chk("model_txd", txd, e_txd);
        chk("model_busy", busy, e_busy);
        chk("model_fifo_count", fifo_count, e_count);
        chk("model_wr_ready", wr_ready, e_ready);

        if (!rstn) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (txd === 1'b0) begin
                rx_active = 1'b1;
                rx_t      = 0;
            end
        end else begin
            rx_t++;
            if (rx_t == DIV / 2) chk("rx_start_bit", txd, 0);
            if ((rx_t % DIV) == DIV / 2 && rx_t / DIV >= 1 && rx_t / DIV <= 8)
                rx_byte[rx_t / DIV - 1] = txd;
            if (rx_t == 9 * DIV + DIV / 2) begin
                chk("rx_stop_bit", txd, 1);
                rx_q.push_back(rx_byte);
            end
            if (rx_t == FRAME - 1) rx_active = 1'b0;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic expect_rx(input string name, input logic [7:0] exp);
        int w;
        w = 0;
        while (rx_q.size() == 0 && w < 3000) begin
            step();
            w++;
        end
        if (rx_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: no frame decoded within %0d cycles, required %02h", name, w, exp);
        end else begin
            chk(name, rx_q.pop_front(), exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int w;
        w = 0;
        while (busy && w < 3000) begin
            step();
            w++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL %s: busy=%0b after %0d cycles, required 0", name, busy, w);
        end
    endtask

    logic t1_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int n;
        step(3);
        chk("reset_txd", txd, 1);
        chk("reset_busy", busy, 0);
        chk("reset_fifo_count", fifo_count, 0);
        chk("reset_wr_ready", wr_ready, 1);
        rstn = 1'b1;
        step(4);

        // Single byte 0x55 with rts settled high.
        wr_valid = 1'b1; wr_data = 8'h55;
        step();
        wr_valid = 1'b0;
        chk("t1_count_n", fifo_count, 1);
        step();
        chk("t1_txd_n1", txd, 1);
        chk("t1_busy_n1", busy, 0);
        step();
        chk("t1_txd_n2", txd, 0);
        chk("t1_busy_n2", busy, 1);
        step(5);
        chk("t1_start_mid", txd, 0);
        for (int k = 0; k < 8; k++) begin
            step(DIV);
            chk($sformatf("t1_bit%0d", k), txd, t1_bits[k]);
        end
        step(DIV);
        chk("t1_stop_mid", txd, 1);
        step(4);
        chk("t1_busy_n101", busy, 1);
        step();
        chk("t1_busy_n102", busy, 0);
        chk("t1_txd_n102", txd, 1);
        expect_rx("t1_rx", 8'h55);

        // Nine back-to-back writes with rts high: all accepted.
        for (int i = 0; i < 9; i++) begin
            wr_valid = 1'b1; wr_data = 8'(i);
            chk("t2_ready", wr_ready, 1);
            step();
        end
        wr_valid = 1'b0;
        chk("t2_count", fifo_count, 8);
        for (int i = 0; i < 9; i++) expect_rx($sformatf("t2_rx%0d", i), 8'(i));
        wait_idle("t2_idle");

        // Same with rts low: only eight fit.
        rts = 1'b0;
        step(4);
        for (int i = 0; i < 9; i++) begin
            wr_valid = 1'b1; wr_data = 8'(8'h10 + i);
            chk($sformatf("t2b_ready%0d", i), wr_ready, (i < 8) ? 1 : 0);
            step();
        end
        wr_valid = 1'b0;
        chk("t2b_count", fifo_count, 8);
        chk("t2b_full_ready", wr_ready, 0);
        rts = 1'b1;
        n = 0;
        while (!busy && n < 20) begin step(); n++; end
        n = 0;
        while (busy && n < 2000) begin step(); n++; end
        chk("t2b_busy_cycles", n, 800);
        for (int i = 0; i < 8; i++) expect_rx($sformatf("t2b_rx%0d", i), 8'(8'h10 + i));
        chk("t2b_count_end", fifo_count, 0);

        // rts held low, then released.
        rts = 1'b0;
        step(4);
        wr_valid = 1'b1; wr_data = 8'hA3;
        step();
        wr_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("t3_hold_txd", txd, 1);
            chk("t3_hold_count", fifo_count, 1);
        end
        rts = 1'b1;
        step();
        chk("t3_txd_m", txd, 1);
        step();
        chk("t3_txd_m1", txd, 1);
        step();
        chk("t3_txd_m2", txd, 1);
        step();
        chk("t3_txd_m3", txd, 0);
        expect_rx("t3_rx", 8'hA3);
        wait_idle("t3_idle");

        // rts drops during bit 4 of 0xF0 with 0xAA queued.
        wr_valid = 1'b1; wr_data = 8'hF0;
        step();
        wr_data = 8'hAA;
        step();
        wr_valid = 1'b0;
        step(55);
        chk("t4_bit4", txd, 1);
        rts = 1'b0;
        expect_rx("t4_rx0", 8'hF0);
        wait_idle("t4_idle");
        for (int i = 0; i < 30; i++) begin
            step();
            chk("t4_hold_txd", txd, 1);
            chk("t4_hold_count", fifo_count, 1);
        end
        rts = 1'b1;
        expect_rx("t4_rx1", 8'hAA);
        wait_idle("t4_idle2");

        // Reset in the middle of a data bit.
        wr_valid = 1'b1; wr_data = 8'h5A;
        step();
        wr_data = 8'h66;
        step();
        wr_valid = 1'b0;
        step(40);
        rstn = 1'b0;
        step();
        chk("t5_txd", txd, 1);
        chk("t5_busy", busy, 0);
        chk("t5_count", fifo_count, 0);
        chk("t5_ready", wr_ready, 1);
        rstn = 1'b1;
        step(4);
        wr_valid = 1'b1; wr_data = 8'h3C;
        step();
        wr_valid = 1'b0;
        expect_rx("t5_rx", 8'h3C);
        wait_idle("t5_idle");
        chk("t5_no_extra", rx_q.size(), 0);

        // Write lands on the same edge as the pop with one byte queued.
        wr_valid = 1'b1; wr_data = 8'h81;
        step();
        chk("t6_count_n", fifo_count, 1);
        wr_data = 8'h7E;
        step();
        wr_valid = 1'b0;
        chk("t6_count_n1", fifo_count, 1);
        expect_rx("t6_rx0", 8'h81);
        expect_rx("t6_rx1", 8'h7E);
        wait_idle("t6_idle");
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
